// File: rtl/mult_div_unit.sv
// Iterative MIPS multiply/divide unit with architectural HI/LO registers.
// Define MDU_DIV_EN to build the restoring divider; otherwise DIV/DIVU complete at once and leave HI/LO unchanged.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] rs_data,
    input  logic [WIDTH-1:0] rt_data,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;
    typedef enum logic [2:0] {
        OP_MULT  = 3'b000,
        OP_MULTU = 3'b001,
        OP_DIV   = 3'b010,
        OP_DIVU  = 3'b011,
        OP_MTHI  = 3'b100,
        OP_MTLO  = 3'b101,
        OP_NOP6  = 3'b110,
        OP_NOP7  = 3'b111
    } op_t;

    state_t             state;
    logic [CW-1:0]      cnt;
    logic [WIDTH-1:0]   opnd;
    logic [2*WIDTH-1:0] acc;
    logic               neg_res;

    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] next_mul;
    logic [2*WIDTH-1:0] mul_res;
    logic [WIDTH-1:0]   fix_hi;
    logic [WIDTH-1:0]   fix_lo;

    function automatic logic [WIDTH-1:0] magn(input logic [WIDTH-1:0] x);
        return x[WIDTH-1] ? -x : x;
    endfunction

`ifdef MDU_DIV_EN
    op_t                op_r;
    logic               neg_rem;
    logic               b_zero;
    logic [WIDTH-1:0]   a_raw;
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic [2*WIDTH-1:0] next_div;
    logic               run_div;
`endif

    // acc holds {upper partial product, unconsumed multiplier bits}; one multiplier bit retires per cycle
    always_comb begin
        mul_sum  = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, (acc[0] ? opnd : {WIDTH{1'b0}})};
        next_mul = {mul_sum, acc[WIDTH-1:1]};
        mul_res  = neg_res ? -acc : acc;
        fix_hi   = mul_res[2*WIDTH-1:WIDTH];
        fix_lo   = mul_res[WIDTH-1:0];
`ifdef MDU_DIV_EN
        // acc holds {partial remainder, dividend bits shifting out / quotient bits shifting in}
        div_shift = acc[2*WIDTH-1:WIDTH-1];
        div_diff  = div_shift - {1'b0, opnd};
        next_div  = div_diff[WIDTH] ? {div_shift[WIDTH-1:0], acc[WIDTH-2:0], 1'b0}
                                    : {div_diff[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
        run_div   = (op_r == OP_DIV) || (op_r == OP_DIVU);
        if (run_div) begin
            if (b_zero) begin
                fix_hi = a_raw;
                fix_lo = '1;
            end else begin
                fix_hi = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
                fix_lo = neg_res ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
            end
        end
`endif
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            cnt     <= '0;
            opnd    <= '0;
            acc     <= '0;
            neg_res <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            hi      <= '0;
            lo      <= '0;
`ifdef MDU_DIV_EN
            op_r    <= OP_MULT;
            neg_rem <= 1'b0;
            b_zero  <= 1'b0;
            a_raw   <= '0;
`endif
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: begin
                    if (start) begin
                        case (op_t'(op))
                            OP_MULT: begin
                                opnd    <= magn(rs_data);
                                acc     <= {{WIDTH{1'b0}}, magn(rt_data)};
                                neg_res <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
`ifdef MDU_DIV_EN
                                op_r    <= OP_MULT;
`endif
                            end
                            OP_MULTU: begin
                                opnd    <= rs_data;
                                acc     <= {{WIDTH{1'b0}}, rt_data};
                                neg_res <= 1'b0;
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
`ifdef MDU_DIV_EN
                                op_r    <= OP_MULTU;
`endif
                            end
`ifdef MDU_DIV_EN
                            OP_DIV: begin
                                opnd    <= magn(rt_data);
                                acc     <= {{WIDTH{1'b0}}, magn(rs_data)};
                                neg_res <= rs_data[WIDTH-1] ^ rt_data[WIDTH-1];
                                neg_rem <= rs_data[WIDTH-1];
                                b_zero  <= (rt_data == '0);
                                a_raw   <= rs_data;
                                op_r    <= OP_DIV;
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
                            OP_DIVU: begin
                                opnd    <= rt_data;
                                acc     <= {{WIDTH{1'b0}}, rs_data};
                                neg_res <= 1'b0;
                                neg_rem <= 1'b0;
                                b_zero  <= (rt_data == '0);
                                a_raw   <= rs_data;
                                op_r    <= OP_DIVU;
                                cnt     <= '0;
                                busy    <= 1'b1;
                                state   <= RUN;
                            end
`else
                            OP_DIV, OP_DIVU: done <= 1'b1;
`endif
                            OP_MTHI: begin
                                hi   <= rs_data;
                                done <= 1'b1;
                            end
                            OP_MTLO: begin
                                lo   <= rs_data;
                                done <= 1'b1;
                            end
                            default: ;
                        endcase
                    end
                end
                RUN: begin
`ifdef MDU_DIV_EN
                    acc <= run_div ? next_div : next_mul;
`else
                    acc <= next_mul;
`endif
                    cnt <= cnt + 1'b1;
                    if (cnt == CW'(WIDTH - 1))
                        state <= FIX;
                end
                FIX: begin
                    hi    <= fix_hi;
                    lo    <= fix_lo;
                    done  <= 1'b1;
                    busy  <= 1'b0;
                    cnt   <= '0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit: directed test-plan vectors plus random ops against an arithmetic reference model.
// Expectations follow the MDU_DIV_EN build setting.
module tb_mult_div_unit;

    localparam int W = 32;
`ifdef MDU_DIV_EN
    localparam bit DIV_EN = 1'b1;
`else
    localparam bit DIV_EN = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          rst_n;
    logic          start;
    logic [2:0]    op;
    logic [W-1:0]  rs_data;
    logic [W-1:0]  rt_data;
    logic          busy;
    logic          done;
    logic [W-1:0]  hi;
    logic [W-1:0]  lo;

    int            n_checks = 0;
    int            n_pass   = 0;
    logic [W-1:0]  exp_hi   = '0;
    logic [W-1:0]  exp_lo   = '0;

    always #5 clk = ~clk;

    mult_div_unit #(.WIDTH(W)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .start   (start),
        .op      (op),
        .rs_data (rs_data),
        .rt_data (rt_data),
        .busy    (busy),
        .done    (done),
        .hi      (hi),
        .lo      (lo)
    );

    task automatic check1(input string tag, input logic obs, input logic expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %b expected %b", tag, obs, expv);
    endtask

    task automatic check32(input string tag, input logic [W-1:0] obs, input logic [W-1:0] expv);
        n_checks++;
        assert (obs === expv) n_pass++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    endtask

    // Reference: returns {hi, lo} after the op, from plain integer arithmetic
    function automatic logic [63:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                          input logic [31:0] h, input logic [31:0] l);
        longint p;
        int     sa, sb, q, r;
        logic [63:0] u;
        case (o)
            3'd0: begin
                p = longint'($signed(a)) * longint'($signed(b));
                return p;
            end
            3'd1: begin
                u = {32'b0, a} * {32'b0, b};
                return u;
            end
            3'd2: begin
                if (!DIV_EN) return {h, l};
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'd0, 32'h8000_0000};
                sa = a; sb = b;
                q = sa / sb;
                r = sa % sb;
                return {r, q};
            end
            3'd3: begin
                if (!DIV_EN) return {h, l};
                if (b == 32'd0) return {a, 32'hFFFF_FFFF};
                return {a % b, a / b};
            end
            3'd4: return {a, l};
            3'd5: return {h, a};
            default: return {h, l};
        endcase
    endfunction

    // Issue one op and follow it to completion; poke_at>0 raises a competing start mid-run
    task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b, input int poke_at);
        logic [63:0] e;
        bit iter;
        e = model(o, a, b, exp_hi, exp_lo);
        iter = (o < 3'd2) || (DIV_EN && (o == 3'd2 || o == 3'd3));
        @(negedge clk);
        start = 1'b1; op = o; rs_data = a; rt_data = b;
        @(posedge clk); #1;
        start = 1'b0; op = 3'($urandom); rs_data = $urandom; rt_data = $urandom;
        if (iter) begin
            check1("busy_e0", busy, 1'b1);
            check1("done_e0", done, 1'b0);
            for (int i = 1; i <= W; i++) begin
                if (i == poke_at) begin
                    @(negedge clk);
                    start = 1'b1; op = 3'b001; rs_data = $urandom; rt_data = $urandom;
                end
                @(posedge clk); #1;
                start = 1'b0;
                check1("busy_run", busy, 1'b1);
                check1("done_run", done, 1'b0);
                check32("hi_run", hi, exp_hi);
                check32("lo_run", lo, exp_lo);
            end
            @(posedge clk); #1;
            check1("done_fix", done, 1'b1);
            check1("busy_fix", busy, 1'b0);
        end else if (o < 3'd6) begin
            check1("done_imm", done, 1'b1);
            check1("busy_imm", busy, 1'b0);
        end else begin
            check1("done_nop", done, 1'b0);
            check1("busy_nop", busy, 1'b0);
        end
        exp_hi = e[63:32];
        exp_lo = e[31:0];
        check32("hi", hi, exp_hi);
        check32("lo", lo, exp_lo);
    endtask

    task automatic idle_cycle();
        @(negedge clk);
        start = 1'b0;
        @(posedge clk); #1;
        check1("done_idle", done, 1'b0);
        check1("busy_idle", busy, 1'b0);
        check32("hi_idle", hi, exp_hi);
        check32("lo_idle", lo, exp_lo);
    endtask

    initial begin
        bit seen;
        logic [2:0] ro;
        logic [31:0] ra, rb;

        rst_n = 1'b0; start = 1'b0; op = '0; rs_data = '0; rt_data = '0;
        repeat (2) @(posedge clk);
        #1;
        check1("rst_busy", busy, 1'b0);
        check1("rst_done", done, 1'b0);
        check32("rst_hi", hi, 32'd0);
        check32("rst_lo", lo, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        // Test-plan vectors, issued back-to-back on the done edge
        do_op(3'd0, 32'hFFFF_FFFD, 32'd5, 0);
        do_op(3'd1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'hFFFF_FFF9, 32'd2, 0);
        do_op(3'd3, 32'd7, 32'd0, 0);
        do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 0);
        do_op(3'd2, 32'h0000_0064, 32'hFFFF_FFF9, 0);
        do_op(3'd2, 32'hFFFF_FF00, 32'd0, 0);
        idle_cycle();
        do_op(3'd4, 32'h1234_5678, 32'hDEAD_BEEF, 0);
        idle_cycle();
        do_op(3'd5, 32'h8765_4321, 32'd0, 0);
        do_op(3'd0, 32'h7FFF_FFFF, 32'h8000_0000, 10);
        idle_cycle();
        do_op(3'd6, 32'hAAAA_AAAA, 32'h5555_5555, 0);
        do_op(3'd7, 32'h5555_5555, 32'hAAAA_AAAA, 0);
        idle_cycle();

        for (int n = 0; n < 20; n++) begin
            ro = 3'($urandom_range(0, 7));
            ra = $urandom;
            rb = ($urandom_range(0, 4) == 0) ? 32'd0 : $urandom;
            if ($urandom_range(0, 3) == 0) rb = 32'($urandom_range(1, 9));
            do_op(ro, ra, rb, 0);
            if (n % 3 == 0) idle_cycle();
        end

        // Asynchronous reset in the middle of a multiply
        do_op(3'd4, 32'hA5A5_A5A5, 32'd0, 0);
        do_op(3'd5, 32'h5A5A_5A5A, 32'd0, 0);
        @(negedge clk);
        start = 1'b1; op = 3'd0; rs_data = 32'h0001_2345; rt_data = 32'hFFF0_0001;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (19) @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        check1("arst_busy", busy, 1'b0);
        check1("arst_done", done, 1'b0);
        check32("arst_hi", hi, 32'd0);
        check32("arst_lo", lo, 32'd0);
        exp_hi = '0;
        exp_lo = '0;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done || busy) seen = 1'b1;
        end
        check1("no_done_after_rst", seen, 1'b0);
        check32("hi_after_rst", hi, 32'd0);
        do_op(3'd1, 32'h0000_FFFF, 32'h0001_0001, 0);
        idle_cycle();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
